// File: rtl/nebula_axil_slave_bridge_if.sv
// AXI4-Lite slave-side channel bundle (AW, W, B, AR, R) for the register bridge.
interface nebula_axil_slave_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              s_awvalid;
  logic              s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_wvalid;
  logic              s_wready;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic              s_bvalid;
  logic              s_bready;
  logic [1:0]        s_bresp;
  logic              s_arvalid;
  logic              s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_rvalid;
  logic              s_rready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    input  s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output s_arready, s_rvalid, s_rdata, s_rresp
  );

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    output s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  s_arready, s_rvalid, s_rdata, s_rresp
  );
endinterface

// File: rtl/nebula_axil_slave_bridge.sv
// AXI4-Lite slave front-end: joins AW/W, range-checks, and issues single-cycle
// write/read strobes to a downstream register bank with buffered B/R responses.
//
// state   | meaning
// W_IDLE  | collecting AW and W independently
// W_ISSUE | one cycle: write strobe if address valid, latch response
// W_RESP  | B response presented until s_bready
// R_IDLE  | waiting for AR
// R_ISSUE | one cycle: read strobe if address valid, register read data
// R_RESP  | R response presented until s_rready
module nebula_axil_slave_bridge #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter int                 NUM_REGS  = 4,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  nebula_axil_slave_bridge_if.slave axi,
  output logic                  reg_wr_valid,
  output logic [ADDR_W-1:0]     reg_wr_addr,
  output logic [DATA_W-1:0]     reg_wr_data,
  output logic [DATA_W/8-1:0]   reg_wr_strb,
  output logic                  reg_rd_valid,
  output logic [ADDR_W-1:0]     reg_rd_addr,
  input  logic [DATA_W-1:0]     reg_rd_data
);

  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;
  // One extra bit so BASE_ADDR + block size cannot wrap.
  localparam logic [ADDR_W:0] BASE_EXT    = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] LIMIT       = BASE_EXT + (ADDR_W+1)'(NUM_REGS * 4);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= BASE_EXT) && ({1'b0, a} < LIMIT) && (a[1:0] == 2'b00);
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP} r_state_t;

  w_state_t   w_state, w_next;
  r_state_t   r_state, r_next;
  logic       aw_held, w_held;
  logic       aw_hs, w_hs, ar_hs;
  logic       wr_ok, rd_ok;
  logic [1:0] bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q;

  assign aw_hs = axi.s_awvalid && axi.s_awready;
  assign w_hs  = axi.s_wvalid  && axi.s_wready;
  assign ar_hs = axi.s_arvalid && axi.s_arready;
  assign wr_ok = in_range(reg_wr_addr);
  assign rd_ok = in_range(reg_rd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_ISSUE;
      W_ISSUE: w_next = W_RESP;
      W_RESP:  if (axi.s_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_ISSUE;
      R_ISSUE: r_next = R_RESP;
      R_RESP:  if (axi.s_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Strobes are masked by rst so a reset landing on the issue cycle emits nothing.
  always_comb begin
    axi.s_awready = (w_state == W_IDLE) && !aw_held;
    axi.s_wready  = (w_state == W_IDLE) && !w_held;
    axi.s_bvalid  = (w_state == W_RESP);
    axi.s_bresp   = bresp_q;
    reg_wr_valid  = (w_state == W_ISSUE) && wr_ok && !rst;
    axi.s_arready = (r_state == R_IDLE);
    axi.s_rvalid  = (r_state == R_RESP);
    axi.s_rdata   = rdata_q;
    axi.s_rresp   = rresp_q;
    reg_rd_valid  = (r_state == R_ISSUE) && rd_ok && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
      bresp_q     <= RESP_OKAY;
      reg_rd_addr <= '0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        reg_wr_addr <= axi.s_awaddr;
        aw_held     <= 1'b1;
      end
      if (w_hs) begin
        reg_wr_data <= axi.s_wdata;
        reg_wr_strb <= axi.s_wstrb;
        w_held      <= 1'b1;
      end
      if (w_state == W_ISSUE) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (w_state == W_RESP && axi.s_bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (ar_hs) reg_rd_addr <= axi.s_araddr;
      if (r_state == R_ISSUE) begin
        rdata_q <= rd_ok ? reg_rd_data : '0;
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_nebula_axil_slave_bridge.sv
// Directed bench for the AXI4-Lite register bridge with a scoreboard of expected
// register strobes and B/R responses, backed by a small 4-entry register bank.
module tb_nebula_axil_slave_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_wr_valid;
  logic [31:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_rd_valid;
  logic [31:0] reg_rd_addr;
  logic [31:0] reg_rd_data;

  nebula_axil_slave_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  nebula_axil_slave_bridge #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(4), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axi(axi),
    .reg_wr_valid(reg_wr_valid),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb),
    .reg_rd_valid(reg_rd_valid),
    .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data)
  );

  always #5 clk = ~clk;

  // Downstream bank: register 0 resets to 0x8, byte-strobe masked writes.
  logic [31:0] bank [4];
  assign reg_rd_data = bank[reg_rd_addr[3:2]];
  always @(posedge clk) begin
    if (rst) begin
      bank[0] <= 32'h8;
      bank[1] <= 32'h0;
      bank[2] <= 32'h0;
      bank[3] <= 32'h0;
    end else if (reg_wr_valid) begin
      for (int b = 0; b < 4; b++)
        if (reg_wr_strb[b]) bank[reg_wr_addr[3:2]][8*b +: 8] <= reg_wr_data[8*b +: 8];
    end
  end

  int wr_pulses = 0;
  always @(posedge clk) if (reg_wr_valid) wr_pulses <= wr_pulses + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_exp_t;
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  wr_exp_t    wr_q [$];
  logic [1:0] b_q  [$];
  rd_exp_t    rd_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_wr_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr_strobe();
    wr_exp_t e;
    e = wr_q.pop_front();
    chk("wr_addr", reg_wr_addr, e.addr);
    chk("wr_data", reg_wr_data, e.data);
    chk("wr_strb", {28'h0, reg_wr_strb}, {28'h0, e.strb});
  endtask

  task automatic finish_b(input int hold);
    logic [1:0] eb;
    eb = b_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk("bvalid_hold", {31'h0, axi.s_bvalid}, 32'h1);
      chk("bresp_hold", {30'h0, axi.s_bresp}, {30'h0, eb});
      chk("awready_busy", {31'h0, axi.s_awready}, 32'h0);
      chk("wready_busy", {31'h0, axi.s_wready}, 32'h0);
      step();
    end
    axi.s_bready = 1'b1;
    chk("bvalid", {31'h0, axi.s_bvalid}, 32'h1);
    chk("bresp", {30'h0, axi.s_bresp}, {30'h0, eb});
    step();
    axi.s_bready = 1'b0;
    chk("bvalid_done", {31'h0, axi.s_bvalid}, 32'h0);
    chk("awready_back", {31'h0, axi.s_awready}, 32'h1);
    chk("wready_back", {31'h0, axi.s_wready}, 32'h1);
  endtask

  task automatic finish_r(input int hold);
    rd_exp_t e;
    e = rd_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk("rvalid_hold", {31'h0, axi.s_rvalid}, 32'h1);
      chk("rdata_hold", axi.s_rdata, e.data);
      chk("rresp_hold", {30'h0, axi.s_rresp}, {30'h0, e.resp});
      step();
    end
    axi.s_rready = 1'b1;
    chk("rvalid", {31'h0, axi.s_rvalid}, 32'h1);
    chk("rdata", axi.s_rdata, e.data);
    chk("rresp", {30'h0, axi.s_rresp}, {30'h0, e.resp});
    step();
    axi.s_rready = 1'b0;
    chk("rvalid_done", {31'h0, axi.s_rvalid}, 32'h0);
    chk("arready_back", {31'h0, axi.s_arready}, 32'h1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input bit exp_strobe, input logic [1:0] exp_resp, input int hold);
    if (exp_strobe) begin
      wr_q.push_back('{addr, data, strb});
      exp_wr_pulses++;
    end
    b_q.push_back(exp_resp);
    axi.s_awvalid = 1'b1; axi.s_awaddr = addr;
    axi.s_wvalid  = 1'b1; axi.s_wdata  = data; axi.s_wstrb = strb;
    step();
    axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
    chk("wr_strobe", {31'h0, reg_wr_valid}, {31'h0, exp_strobe});
    if (exp_strobe) check_wr_strobe();
    step();
    chk("wr_strobe_single", {31'h0, reg_wr_valid}, 32'h0);
    finish_b(hold);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                         input bit exp_strobe, input int hold);
    rd_q.push_back('{exp_data, exp_resp});
    axi.s_arvalid = 1'b1; axi.s_araddr = addr;
    step();
    axi.s_arvalid = 1'b0;
    chk("arready_busy", {31'h0, axi.s_arready}, 32'h0);
    chk("rd_strobe", {31'h0, reg_rd_valid}, {31'h0, exp_strobe});
    if (exp_strobe) chk("rd_addr", reg_rd_addr, addr);
    chk("rvalid_early", {31'h0, axi.s_rvalid}, 32'h0);
    step();
    finish_r(hold);
  endtask

  initial begin
    rst = 1'b1;
    axi.s_awvalid = 1'b0; axi.s_awaddr = '0;
    axi.s_wvalid  = 1'b0; axi.s_wdata  = '0; axi.s_wstrb = '0;
    axi.s_bready  = 1'b0;
    axi.s_arvalid = 1'b0; axi.s_araddr = '0;
    axi.s_rready  = 1'b0;
    step();
    step();
    chk("rst_awready", {31'h0, axi.s_awready}, 32'h1);
    chk("rst_wready", {31'h0, axi.s_wready}, 32'h1);
    chk("rst_arready", {31'h0, axi.s_arready}, 32'h1);
    chk("rst_bvalid", {31'h0, axi.s_bvalid}, 32'h0);
    chk("rst_rvalid", {31'h0, axi.s_rvalid}, 32'h0);
    chk("rst_bresp", {30'h0, axi.s_bresp}, 32'h0);
    chk("rst_rresp", {30'h0, axi.s_rresp}, 32'h0);
    chk("rst_rdata", axi.s_rdata, 32'h0);
    chk("rst_wr_valid", {31'h0, reg_wr_valid}, 32'h0);
    chk("rst_rd_valid", {31'h0, reg_rd_valid}, 32'h0);
    chk("rst_wr_addr", reg_wr_addr, 32'h0);
    chk("rst_wr_data", reg_wr_data, 32'h0);
    chk("rst_rd_addr", reg_rd_addr, 32'h0);
    rst = 1'b0;
    step();

    // Simultaneous write and read of register 1: read sees the pre-write value.
    wr_q.push_back('{32'h4, 32'h5, 4'hF});
    exp_wr_pulses++;
    b_q.push_back(2'b00);
    rd_q.push_back('{32'h0, 2'b00});
    axi.s_awvalid = 1'b1; axi.s_awaddr = 32'h4;
    axi.s_wvalid  = 1'b1; axi.s_wdata  = 32'h5; axi.s_wstrb = 4'hF;
    axi.s_arvalid = 1'b1; axi.s_araddr = 32'h4;
    step();
    axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0; axi.s_arvalid = 1'b0;
    chk("sim_wr_strobe", {31'h0, reg_wr_valid}, 32'h1);
    chk("sim_rd_strobe", {31'h0, reg_rd_valid}, 32'h1);
    chk("sim_rd_addr", reg_rd_addr, 32'h4);
    check_wr_strobe();
    step();
    chk("sim_rvalid", {31'h0, axi.s_rvalid}, 32'h1);
    finish_r(0);
    finish_b(0);
    do_read(32'h4, 32'h5, 2'b00, 1'b1, 0);

    do_write(32'h4, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00, 0);
    do_read(32'h4, 32'hDEADBEEF, 2'b00, 1'b1, 0);

    // W leads AW by three cycles; response held off for five cycles.
    wr_q.push_back('{32'h8, 32'h12345678, 4'h3});
    exp_wr_pulses++;
    b_q.push_back(2'b00);
    axi.s_wvalid = 1'b1; axi.s_wdata = 32'h12345678; axi.s_wstrb = 4'h3;
    step();
    axi.s_wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("wfirst_wready", {31'h0, axi.s_wready}, 32'h0);
      chk("wfirst_awready", {31'h0, axi.s_awready}, 32'h1);
      chk("wfirst_no_strobe", {31'h0, reg_wr_valid}, 32'h0);
      step();
    end
    axi.s_awvalid = 1'b1; axi.s_awaddr = 32'h8;
    step();
    axi.s_awvalid = 1'b0;
    chk("wfirst_strobe", {31'h0, reg_wr_valid}, 32'h1);
    check_wr_strobe();
    step();
    finish_b(5);

    do_read(32'h0, 32'h8, 2'b00, 1'b1, 4);
    do_read(32'hC, 32'h0, 2'b00, 1'b1, 0);
    do_read(32'h10, 32'h0, 2'b10, 1'b0, 1);
    do_write(32'h6, 32'hCAFEF00D, 4'hF, 1'b0, 2'b10, 2);
    do_write(32'h10, 32'h11111111, 4'hF, 1'b0, 2'b10, 0);
    do_write(32'h8, 32'hFFFFFFFF, 4'h0, 1'b1, 2'b00, 0);
    do_read(32'h8, 32'h00005678, 2'b00, 1'b1, 0);

    // Reset lands on the issue cycle: nothing may reach the bank or the B channel.
    axi.s_awvalid = 1'b1; axi.s_awaddr = 32'h4;
    axi.s_wvalid  = 1'b1; axi.s_wdata  = 32'h1; axi.s_wstrb = 4'hF;
    step();
    axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_no_strobe", {31'h0, reg_wr_valid}, 32'h0);
    step();
    rst = 1'b0;
    chk("rst_mid_bvalid", {31'h0, axi.s_bvalid}, 32'h0);
    chk("rst_mid_awready", {31'h0, axi.s_awready}, 32'h1);
    chk("rst_mid_wready", {31'h0, axi.s_wready}, 32'h1);
    chk("rst_mid_arready", {31'h0, axi.s_arready}, 32'h1);
    chk("rst_mid_wr_addr", reg_wr_addr, 32'h0);
    step();
    chk("rst_mid_bvalid2", {31'h0, axi.s_bvalid}, 32'h0);
    chk("rst_mid_no_strobe2", {31'h0, reg_wr_valid}, 32'h0);
    step();
    chk("wr_pulse_count", wr_pulses, exp_wr_pulses);
    chk("queues_drained", wr_q.size() + b_q.size() + rd_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nebula_axil_slave_bridge.md
Name: nebula_axil_slave_bridge

Overview:
AXI4-Lite slave front-end that terminates the five standard channels (AW, W, B, AR, R) from the cluster interconnect. It converts them into the single-cycle combined write strobe and read strobe consumed by the control/status register bank directly downstream. The block owns all handshaking, AW/W joining, address-range checking and response buffering, so the register bank can stay purely single-cycle.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (fixed 32; other values unsupported)
NUM_REGS, 4, number of 32-bit registers decoded downstream; word index = addr[$clog2(NUM_REGS)+1:2]
BASE_ADDR, 32'h0, byte address of register 0; block size = NUM_REGS*4 bytes

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_awaddr  in  ADDR_W  write byte address
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_wdata  in  DATA_W  write data
s_wstrb  in  DATA_W/8  byte strobes
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_bresp  out  2  00 OKAY, 10 SLVERR
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_araddr  in  ADDR_W  read byte address
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_rdata  out  DATA_W  read data
s_rresp  out  2  00 OKAY, 10 SLVERR
reg_wr_valid  out  1  one-cycle write strobe to register bank
reg_wr_addr  out  ADDR_W  captured AW address (byte)
reg_wr_data  out  DATA_W  captured W data
reg_wr_strb  out  DATA_W/8  captured W strobes
reg_rd_valid  out  1  one-cycle read strobe to register bank
reg_rd_addr  out  ADDR_W  captured AR address (byte)
reg_rd_data  in  DATA_W  register bank read data, combinational from reg_rd_addr

Behaviour:
- Clock clk, synchronous active-high reset rst. Reset values: s_awready=1, s_wready=1, s_arready=1, s_bvalid=0, s_rvalid=0, s_bresp=00, s_rresp=00, s_rdata=0, reg_wr_valid=0, reg_rd_valid=0, reg_*_addr/data/strb=0.
- One outstanding write and one outstanding read; the two paths are independent and may be active in the same cycle.
- Write path, FSM W_IDLE -> W_ISSUE -> W_RESP:
  - W_IDLE: AW and W are captured independently. s_awready drops the cycle after AW is captured; s_wready drops the cycle after W is captured. Either channel may arrive first, or both together.
  - Transition to W_ISSUE on the edge where both are held.
  - W_ISSUE (exactly 1 cycle): if the address is in range and word-aligned, reg_wr_valid=1; otherwise reg_wr_valid stays 0 and SLVERR is latched.
  - W_RESP: s_bvalid=1 and is held with s_bresp stable until s_bready. On the handshake edge return to W_IDLE with awready=wready=1.
- Write latency: last of AW/W handshakes at edge N -> reg_wr_valid high in cycle N+1 -> s_bvalid high from cycle N+2.
- Read path, FSM R_IDLE -> R_ISSUE -> R_RESP:
  - R_IDLE: s_arready=1. Capture on handshake, then drop arready.
  - R_ISSUE (1 cycle): reg_rd_valid=1 if in range, and reg_rd_data is registered into s_rdata. If out of range: s_rdata=0, s_rresp=10, reg_rd_valid=0.
  - R_RESP: s_rvalid=1; s_rdata and s_rresp are held until s_rready. Return to R_IDLE on the handshake edge.
- Read latency: AR handshake at edge N -> reg_rd_valid in N+1 -> s_rvalid from N+2.
- In range means BASE_ADDR <= addr < BASE_ADDR+NUM_REGS*4 and addr[1:0]==0. Comparison is done at ADDR_W width with no wrap.
- s_wstrb is passed through unmodified. Strobe masking is done by the register bank. wstrb=0 still produces a write strobe and an OKAY response.
- Same-cycle read and write strobes to the same register: the read returns the pre-write value (the bank updates on the clock edge).
- VALID outputs never drop without the matching READY. Response data and resp are stable while valid.
- rst asserted mid-transaction: all held requests and responses are discarded, no strobe is emitted, and outputs return to reset values on the next edge.

Test Plan:
- AW addr 0x4 and W data 0xDEADBEEF, strb 0xF, same cycle -> reg_wr_valid 1 cycle later with addr 0x4 and data 0xDEADBEEF; bvalid after 2 cycles, bresp=00.
- W first, AW 3 cycles later, bready held low for 5 cycles -> a single reg_wr_valid pulse; bvalid held 5 cycles; awready/wready stay 0 until the B handshake.
- AR addr 0x0 with bank returning 0x00000008 -> rvalid at N+2 with rdata=0x8 and rresp=00; rready low for 4 cycles keeps rdata stable.
- AR addr 0x10 (NUM_REGS=4) and AW addr 0x6 (misaligned) -> no reg strobes; rresp=10, rdata=0, bresp=10.
- Simultaneous write 0x5 and read to addr 0x4 (old value 0x0) -> both strobes in the same cycle; rdata=0x0; a subsequent read returns 0x5.
- rst pulsed in the cycle after AW/W capture -> no reg_wr_valid, no bvalid; all readies=1 after reset.
